sipo_pack: RTL and testbench
============================

Name: sipo_pack

Overview:
- Datapath stage directly downstream of the frame-fetch FSM.
- Consumes the FSM's byte stream and strobes: data, sipo_en, latch_en, dp1_en..dp4_en, wr, done_frame.
- Shifts bytes into a 32-bit SIPO, latches the result, and distributes it to four 32-bit data-port registers.
- Packs the four ports into 128-bit words, queued in a small FIFO with valid/ready output.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of 2, >=2
CNT_W, 16, width of word_cnt

Ports:
clk  in  1  clock, all logic on posedge
reset_  in  1  reset, synchronous, active-low
data  in  8  byte from frame memory
sipo_en  in  1  shift data into SIPO
latch_en  in  1  capture SIPO into latch
dp1_en  in  1  load latch into data port 1
dp2_en  in  1  load latch into data port 2
dp3_en  in  1  load latch into data port 3
dp4_en  in  1  load latch into data port 4
wr  in  1  push {dp1,dp2,dp3,dp4} into FIFO
done_frame  in  1  marks the word pushed this cycle as frame end
out_data  out  128  FIFO head; 0 when out_valid=0
out_last  out  1  head entry is the last word of its frame; 0 when out_valid=0
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head
fifo_full  out  1  FIFO count == FIFO_DEPTH
overflow  out  1  sticky: a wr was dropped
word_cnt  out  CNT_W  accepted pushes since reset; wraps
sipo_err  out  1  see Optional Feature

Behaviour:
- Reset (reset_=0 at posedge):
  - Clears sipo, latch, dp1..dp4, FIFO pointers/count, overflow, word_cnt, sipo_err.
  - All outputs read 0 the following cycle.
  - All strobes are ignored during that cycle.
  - Reset mid-frame flushes every queued entry.
- SIPO shift: when sipo_en, sipo <= {sipo[23:0], data}. The first of four bytes ends in bits [31:24].
- Latch: when latch_en, latch <= sipo, using the pre-shift value. If sipo_en and latch_en coincide, latch gets the old sipo and the shift still occurs.
- Port load: when dpN_en, dpN <= latch, using the pre-update latch. Several dpN_en may be high together; each port loads independently.
- Push: wr pushes {dp1,dp2,dp3,dp4}, with dp1 at bits [127:96].
  - Uses pre-update port values: a dpN_en in the same cycle is not seen by this push.
  - The entry's last bit = done_frame in that cycle.
  - done_frame without wr has no effect.
- Accept/drop rules:
  - Push accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow <= 1. overflow clears only on reset.
- Pop: when out_valid && out_ready, the head advances.
- Latency: out_valid rises the cycle after an accepted wr into an empty FIFO. out_data is presented first-word-fall-through from registered storage.
- Count: count += push_accepted - pop, so simultaneous push and pop leave it unchanged. fifo_full = (count == FIFO_DEPTH), registered-derived.
- Empty pop: out_ready while empty is ignored.
- word_cnt: increments on each accepted push; wraps all-ones -> 0.
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally.

Optional Feature:
- Macro: SIPO_CHECK_EN.
- With it defined:
  - A 3-bit counter counts sipo_en pulses since the last latch_en, saturating at 4.
  - latch_en with counter != 4 sets sipo_err. sipo_err is sticky until reset.
  - latch_en clears the counter to 0, or to 1 if sipo_en coincides.
- Without it: sipo_err is tied to 0 and no counter logic exists.

Test Plan:
- Reset: hold reset_=0 for 2 cycles with all strobes high -> all outputs 0, word_cnt=0.
- Single word, out_ready=1:
  - Stimulus: 4x(sipo_en with 4 bytes, latch_en, dpN_en), bytes 11,22,33,44 / 55,66,77,88 / 99,AA,BB,CC / DD,EE,FF,00; then wr with done_frame=1.
  - Response: next cycle out_valid=1, out_last=1, out_data=128'h11223344_55667788_99AABBCC_DDEEFF00; one cycle later out_valid=0; word_cnt=1.
- Backpressure, out_ready=0, 5 wr pulses of distinct words:
  - fifo_full=1 after the 4th; the 5th is dropped; overflow=1; word_cnt=4.
  - Raising out_ready pops words 1-4 in order, then out_valid=0.
- Full plus simultaneous events: with FIFO full, assert wr and out_ready in the same cycle -> push accepted, count stays 4, overflow stays 0.
- Same-cycle hazards:
  - latch_en with sipo_en -> latch holds the pre-shift value.
  - wr with dp1_en -> pushed dp1 is the old value.
  - Reset asserted with 3 entries queued -> out_valid=0 next cycle.
- SIPO_CHECK_EN:
  - Latch after 3 sipo_en pulses -> sipo_err=1, persists.
  - Without the macro, the same stimulus -> sipo_err=0.

Source files
------------

// File: rtl/sipo_pack.sv
// Byte-to-128-bit packing stage: 32-bit SIPO -> latch -> four data ports -> valid/ready FIFO.
// Optional SIPO_CHECK_EN macro adds a sticky error flag for latches that do not follow exactly four shifts.
module sipo_pack #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [7:0]       data,
  input  logic             sipo_en,
  input  logic             latch_en,
  input  logic             dp1_en,
  input  logic             dp2_en,
  input  logic             dp3_en,
  input  logic             dp4_en,
  input  logic             wr,
  input  logic             done_frame,
  output logic [127:0]     out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fifo_full,
  output logic             overflow,
  output logic [CNT_W-1:0] word_cnt,
  output logic             sipo_err
);

  localparam int             PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic         last;
    logic [127:0] data;
  } entry_t;

  logic [31:0]      sipo;
  logic [31:0]      latch_r;
  logic [31:0]      dp1, dp2, dp3, dp4;
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             pop;
  logic             push_ok;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = wr && ((count < DEPTH_C) || pop);
  assign fifo_full = (count == DEPTH_C);
  assign out_data  = out_valid ? mem[rd_ptr].data : '0;
  assign out_last  = out_valid && mem[rd_ptr].last;

  // NOTE: non-blocking updates make every stage read its source's pre-edge value,
  // so a same-cycle shift/latch/load/push chain never sees this cycle's update.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      sipo    <= '0;
      latch_r <= '0;
      dp1     <= '0;
      dp2     <= '0;
      dp3     <= '0;
      dp4     <= '0;
    end else begin
      if (sipo_en)  sipo    <= {sipo[23:0], data};
      if (latch_en) latch_r <= sipo;
      if (dp1_en)   dp1     <= latch_r;
      if (dp2_en)   dp2     <= latch_r;
      if (dp3_en)   dp3     <= latch_r;
      if (dp4_en)   dp4     <= latch_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr && !push_ok) overflow <= 1'b1;
      count <= count + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop);
    end
  end

  // NOTE: entry storage has no reset; count alone decides which entries are visible.
  always_ff @(posedge clk) begin
    if (reset_ && push_ok) mem[wr_ptr] <= '{last: done_frame, data: {dp1, dp2, dp3, dp4}};
  end

`ifdef SIPO_CHECK_EN
  logic [2:0] shift_cnt;

  // Counts shifts since the last latch, saturating at a full word of four bytes.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      shift_cnt <= '0;
      sipo_err  <= 1'b0;
    end else if (latch_en) begin
      if (shift_cnt != 3'd4) sipo_err <= 1'b1;
      shift_cnt <= sipo_en ? 3'd1 : 3'd0;
    end else if (sipo_en && shift_cnt != 3'd4) begin
      shift_cnt <= shift_cnt + 3'd1;
    end
  end
`else
  assign sipo_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_pack.sv
// Self-checking bench for sipo_pack: queue-based reference model compared every cycle,
// plus directed literal checks for the headline scenarios.
module tb_sipo_pack;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             reset_;
  logic [7:0]       data;
  logic             sipo_en, latch_en, dp1_en, dp2_en, dp3_en, dp4_en, wr, done_frame;
  logic [127:0]     out_data;
  logic             out_last, out_valid, out_ready, fifo_full, overflow, sipo_err;
  logic [CNT_W-1:0] word_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  sipo_pack #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_(reset_), .data(data), .sipo_en(sipo_en), .latch_en(latch_en),
    .dp1_en(dp1_en), .dp2_en(dp2_en), .dp3_en(dp3_en), .dp4_en(dp4_en), .wr(wr),
    .done_frame(done_frame), .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_full(fifo_full), .overflow(overflow), .word_cnt(word_cnt),
    .sipo_err(sipo_err)
  );

  always #5 clk = ~clk;

  // Reference model: the SIPO is the last four bytes shifted in, the FIFO a queue.
  logic [7:0]       m_bytes[$];
  logic [31:0]      m_latch = '0;
  logic [31:0]      m_dp [4] = '{default: '0};
  logic [128:0]     m_fifo[$];
  logic             m_ovf = 1'b0;
  logic [CNT_W-1:0] m_wc  = '0;
  logic             m_err = 1'b0;
`ifdef SIPO_CHECK_EN
  int m_since = 0;
`endif

  function automatic logic [31:0] sipo_val();
    logic [31:0] r = '0;
    foreach (m_bytes[i]) r = (r << 8) | 32'(m_bytes[i]);
    return r;
  endfunction

  always @(posedge clk) begin
    logic [31:0] s_old;
    logic [31:0] l_old;
    bit          do_pop;
    bit          do_acc;
    if (!reset_) begin
      m_bytes.delete();
      m_fifo.delete();
      m_latch <= '0;
      m_dp    <= '{default: '0};
      m_ovf   <= 1'b0;
      m_wc    <= '0;
      m_err   <= 1'b0;
`ifdef SIPO_CHECK_EN
      m_since <= 0;
`endif
    end else begin
      s_old  = sipo_val();
      l_old  = m_latch;
      do_pop = (m_fifo.size() != 0) && out_ready;
      do_acc = wr && ((m_fifo.size() < FIFO_DEPTH) || do_pop);
      if (do_pop) void'(m_fifo.pop_front());
      if (do_acc) begin
        m_fifo.push_back({done_frame, m_dp[0], m_dp[1], m_dp[2], m_dp[3]});
        m_wc <= m_wc + 1'b1;
      end else if (wr) begin
        m_ovf <= 1'b1;
      end
      if (sipo_en) begin
        m_bytes.push_back(data);
        if (m_bytes.size() > 4) void'(m_bytes.pop_front());
      end
      if (latch_en) m_latch <= s_old;
      if (dp1_en) m_dp[0] <= l_old;
      if (dp2_en) m_dp[1] <= l_old;
      if (dp3_en) m_dp[2] <= l_old;
      if (dp4_en) m_dp[3] <= l_old;
`ifdef SIPO_CHECK_EN
      if (latch_en) begin
        if (m_since < 4) m_err <= 1'b1;
        m_since <= sipo_en ? 1 : 0;
      end else if (sipo_en) begin
        m_since <= m_since + 1;
      end
`endif
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit v = (m_fifo.size() != 0);
    check("out_valid", 128'(out_valid), 128'(v));
    check("out_data", out_data, v ? m_fifo[0][127:0] : 128'h0);
    check("out_last", 128'(out_last), v ? 128'(m_fifo[0][128]) : 128'h0);
    check("fifo_full", 128'(fifo_full), 128'(m_fifo.size() == FIFO_DEPTH));
    check("overflow", 128'(overflow), 128'(m_ovf));
    check("word_cnt", 128'(word_cnt), 128'(m_wc));
    check("sipo_err", 128'(sipo_err), 128'(m_err));
  endtask

  task automatic clear_strobes();
    {sipo_en, latch_en, dp1_en, dp2_en, dp3_en, dp4_en, wr, done_frame} = '0;
    data = 8'h00;
  endtask

  // One clock: model compare on the falling edge, then strobes drop just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) compare_model();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    cyc();
    reset_ = 1'b1;
  endtask

  task automatic shift(input logic [7:0] b);
    sipo_en = 1'b1;
    data    = b;
    cyc();
  endtask

  task automatic load_word(input logic [127:0] w);
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 4; b++) shift(w[127 - 32*p - 8*b -: 8]);
      latch_en = 1'b1;
      cyc();
      case (p)
        0: dp1_en = 1'b1;
        1: dp2_en = 1'b1;
        2: dp3_en = 1'b1;
        default: dp4_en = 1'b1;
      endcase
      cyc();
    end
  endtask

  task automatic push(input logic last);
    wr         = 1'b1;
    done_frame = last;
    cyc();
  endtask

  function automatic logic [127:0] mk_word(input int k);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(16*k + i + 1);
    return r;
  endfunction

  initial begin
    logic [127:0] w_new;
    // Reset held two cycles with every strobe high.
    reset_    = 1'b0;
    out_ready = 1'b1;
    data      = 8'hFF;
    {sipo_en, latch_en, dp1_en, dp2_en, dp3_en, dp4_en, wr, done_frame} = '1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_out_valid", 128'(out_valid), 128'h0);
    check("rst_out_data", out_data, 128'h0);
    check("rst_fifo_full", 128'(fifo_full), 128'h0);
    check("rst_overflow", 128'(overflow), 128'h0);
    check("rst_word_cnt", 128'(word_cnt), 128'h0);
    check("rst_sipo_err", 128'(sipo_err), 128'h0);
    reset_ = 1'b1;
    clear_strobes();

    // Single word streamed straight through.
    load_word(128'h11223344_55667788_99AABBCC_DDEEFF00);
    push(1'b1);
    check("single_valid", 128'(out_valid), 128'h1);
    check("single_last", 128'(out_last), 128'h1);
    check("single_data", out_data, 128'h11223344_55667788_99AABBCC_DDEEFF00);
    cyc();
    check("single_drained", 128'(out_valid), 128'h0);
    check("single_word_cnt", 128'(word_cnt), 128'h1);

    // Backpressure: four queued, fifth dropped, then drained in order.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      load_word(mk_word(k));
      push(1'b0);
      if (k == 3) check("bp_full", 128'(fifo_full), 128'h1);
    end
    check("bp_overflow", 128'(overflow), 128'h1);
    check("bp_word_cnt", 128'(word_cnt), 128'h4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_order%0d", k), out_data, mk_word(k));
      cyc();
    end
    check("bp_empty", 128'(out_valid), 128'h0);

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    out_ready = 1'b0;
    load_word(mk_word(7));
    repeat (4) push(1'b0);
    w_new = mk_word(9);
    load_word(w_new);
    wr        = 1'b1;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("sim_full", 128'(fifo_full), 128'h1);
    check("sim_overflow", 128'(overflow), 128'h0);
    check("sim_word_cnt", 128'(word_cnt), 128'h5);
    out_ready = 1'b1;
    repeat (3) cyc();
    check("sim_tail", out_data, w_new);
    cyc();

    // Same-cycle hazards.
    do_reset();
    out_ready = 1'b1;
    shift(8'hA1); shift(8'hA2); shift(8'hA3); shift(8'hA4);
    sipo_en  = 1'b1;
    data     = 8'hB5;
    latch_en = 1'b1;
    cyc();
    dp1_en = 1'b1;
    cyc();
    push(1'b0);
    check("haz_latch_preshift", out_data, {32'hA1A2A3A4, 96'h0});
    latch_en = 1'b1;
    cyc();
    wr     = 1'b1;
    dp1_en = 1'b1;
    cyc();
    check("haz_wr_old_dp1", out_data, {32'hA1A2A3A4, 96'h0});
    push(1'b1);
    check("haz_new_dp1", out_data, {32'hA2A3A4B5, 96'h0});
    check("haz_new_last", 128'(out_last), 128'h1);
    cyc();

    // Reset flushes queued entries.
    out_ready = 1'b0;
    repeat (3) push(1'b0);
    check("pre_flush_cnt", 128'(word_cnt), 128'h6);
    do_reset();
    check("flush_valid", 128'(out_valid), 128'h0);
    check("flush_word_cnt", 128'(word_cnt), 128'h0);

    // Short shift run before a latch.
    shift(8'h01); shift(8'h02); shift(8'h03);
    latch_en = 1'b1;
    cyc();
`ifdef SIPO_CHECK_EN
    check("sipo_err_set", 128'(sipo_err), 128'h1);
`else
    check("sipo_err_tied", 128'(sipo_err), 128'h0);
`endif
    repeat (2) cyc();
`ifdef SIPO_CHECK_EN
    check("sipo_err_sticky", 128'(sipo_err), 128'h1);
`else
    check("sipo_err_still0", 128'(sipo_err), 128'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
